// File: rtl/maze_move_checker_if.sv
// Move-request, maze-ROM and sprite-position bundle
// shared by the maze player engine and its environment.
interface maze_move_checker_if;
  logic        req;
  logic [1:0]  dir;
  logic [12:0] index;
  logic [15:0] data;
  logic [6:0]  pos_x;
  logic [5:0]  pos_y;
  logic        busy;
  logic        done;
  logic        blocked;
  logic        goal;

  modport master (
    output req, dir, data,
    input  index, pos_x, pos_y,
    input  busy, done, blocked, goal
  );

  modport slave (
    input  req, dir, data,
    output index, pos_x, pos_y,
    output busy, done, blocked, goal
  );
endinterface

// File: rtl/maze_move_checker.sv
// Player-movement engine: scans the target sprite footprint in
// the maze ROM and commits the move only when it hits no wall.
module maze_move_checker #(
  parameter int          SPRITE     = 3,
  parameter int          ROM_LAT    = 1,
  parameter logic [15:0] WALL_COLOR = 16'hFFFF,
  parameter logic [15:0] GOAL_COLOR = 16'h001F,
  parameter int          START_X    = 4,
  parameter int          START_Y    = 4
) (
  input logic                clk,
  input logic                reset,
  maze_move_checker_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CALC  = 2'd1;
  localparam logic [1:0] SCAN  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam logic [3:0] LAST  = 4'(SPRITE - 1);
  localparam logic [8:0] XSPAN = 9'(SPRITE - 1);
  localparam logic [7:0] YSPAN = 8'(SPRITE - 1);

  logic [1:0]         state_q, state_d;
  logic [7:0]         tx_q, tx_d;
  logic [6:0]         ty_q, ty_d;
  logic [12:0]        index_q, index_d;
  logic [12:0]        rowb_q, rowb_d;
  logic [3:0]         col_q, col_d;
  logic [3:0]         row_q, row_d;
  logic [ROM_LAT-1:0] tag_q, tag_d;
  logic               wacc_q, wacc_d;
  logic               gacc_q, gacc_d;
  logic [6:0]         pos_x_q, pos_x_d;
  logic [5:0]         pos_y_q, pos_y_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               blk_q, blk_d;
  logic               goal_q, goal_d;

  logic        issue;
  logic        tag_out;
  logic        retire;
  logic        oob;
  logic [12:0] base;

  // Target coords are kept one bit wider so x-1/y-1 at 0 wraps high.
  assign tag_out = tag_q[ROM_LAT-1];
  assign retire  = tag_out && ((tag_q << 1) == '0);
  assign oob     = ({1'b0, tx_q} + XSPAN > 9'd95) ||
                   ({1'b0, ty_q} + YSPAN > 8'd63);
  assign base    = ({6'd0, ty_q} << 6) +
                   ({6'd0, ty_q} << 5) +
                   {5'd0, tx_q};

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    index_d = index_q;
    rowb_d  = rowb_q;
    col_d   = col_q;
    row_d   = row_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    blk_d   = blk_q;
    goal_d  = goal_q;
    issue   = 1'b0;
    wacc_d  = wacc_q | (tag_out && bus.data == WALL_COLOR);
    gacc_d  = gacc_q | (tag_out && bus.data == GOAL_COLOR);

    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          busy_d  = 1'b1;
          state_d = CALC;
          tx_d    = {1'b0, pos_x_q};
          ty_d    = {1'b0, pos_y_q};
          unique case (bus.dir)
            2'd0:    ty_d = {1'b0, pos_y_q} - 7'd1;
            2'd1:    ty_d = {1'b0, pos_y_q} + 7'd1;
            2'd2:    tx_d = {1'b0, pos_x_q} - 8'd1;
            default: tx_d = {1'b0, pos_x_q} + 8'd1;
          endcase
        end
      end
      CALC: begin
        if (oob) begin
          blk_d   = 1'b1;
          goal_d  = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          index_d = base;
          rowb_d  = base;
          col_d   = 4'd0;
          row_d   = 4'd0;
          wacc_d  = 1'b0;
          gacc_d  = 1'b0;
          issue   = 1'b1;
          state_d = (LAST == 4'd0) ? DRAIN : SCAN;
        end
      end
      SCAN: begin
        issue = 1'b1;
        if (col_q == LAST) begin
          rowb_d  = rowb_q + 13'd96;
          index_d = rowb_q + 13'd96;
          col_d   = 4'd0;
          row_d   = row_q + 4'd1;
        end else begin
          index_d = index_q + 13'd1;
          col_d   = col_q + 4'd1;
        end
        if (row_d == LAST && col_d == LAST)
          state_d = DRAIN;
      end
      default: begin
        // Final compare and commit share this edge.
        if (retire) begin
          blk_d  = wacc_d;
          goal_d = gacc_d & ~wacc_d;
          if (!wacc_d) begin
            pos_x_d = tx_q[6:0];
            pos_y_d = ty_q[5:0];
          end
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
    endcase

    tag_d[0] = issue;
    for (int i = 1; i < ROM_LAT; i++)
      tag_d[i] = tag_q[i-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tx_q    <= '0;
      ty_q    <= '0;
      index_q <= '0;
      rowb_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      tag_q   <= '0;
      wacc_q  <= 1'b0;
      gacc_q  <= 1'b0;
      pos_x_q <= 7'(START_X);
      pos_y_q <= 6'(START_Y);
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      blk_q   <= 1'b0;
      goal_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      index_q <= index_d;
      rowb_q  <= rowb_d;
      col_q   <= col_d;
      row_q   <= row_d;
      tag_q   <= tag_d;
      wacc_q  <= wacc_d;
      gacc_q  <= gacc_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      blk_q   <= blk_d;
      goal_q  <= goal_d;
    end
  end

  assign bus.index   = index_q;
  assign bus.pos_x   = pos_x_q;
  assign bus.pos_y   = pos_y_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.blocked = blk_q;
  assign bus.goal    = goal_q;

endmodule

// File: tb/tb_maze_move_checker.sv
// Bench for maze_move_checker: vector table, corner
// sequences and random moves against a footprint model.
module tb_maze_move_checker;
  localparam int S   = 3;
  localparam int LAT = 1;
  localparam int SQ  = S * S;
  localparam int SX  = 4;
  localparam int SY  = 4;
  localparam logic [15:0] WALL = 16'hFFFF;
  localparam logic [15:0] GOAL = 16'h001F;

  logic clk = 1'b0;
  logic reset;
  maze_move_checker_if bus ();
  logic [15:0] rom [0:6143];
  int checks = 0;
  int errors = 0;
  int mx, my;

  maze_move_checker #(
    .SPRITE(S), .ROM_LAT(LAT),
    .WALL_COLOR(WALL), .GOAL_COLOR(GOAL),
    .START_X(SX), .START_Y(SY)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.data = (bus.index < 13'd6144) ? rom[bus.index] : 16'h0000;

  typedef struct {
    int dir;
    int wx, wy, gx, gy;
    int ex, ey;
    bit eb, eg;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_rom();
    foreach (rom[i]) rom[i] = 16'h0000;
  endtask

  function automatic void ref_move(
    input int x, input int y, input int d,
    output int tx, output int ty, output int nx, output int ny,
    output bit blk, output bit gl, output bit oob, output int lat);
    bit w, g;
    w = 0;
    g = 0;
    tx = x;
    ty = y;
    case (d)
      0: ty = y - 1;
      1: ty = y + 1;
      2: tx = x - 1;
      default: tx = x + 1;
    endcase
    oob = tx < 0 || ty < 0 || tx + S - 1 > 95 || ty + S - 1 > 63;
    if (!oob)
      for (int r = 0; r < S; r++)
        for (int c = 0; c < S; c++) begin
          if (rom[(ty + r) * 96 + tx + c] == WALL) w = 1;
          if (rom[(ty + r) * 96 + tx + c] == GOAL) g = 1;
        end
    blk = oob || w;
    gl  = !oob && g && !w;
    nx  = blk ? x : tx;
    ny  = blk ? y : ty;
    lat = oob ? 1 : SQ + LAT;
  endfunction

  task automatic do_reset();
    bus.req = 1'b0;
    bus.dir = 2'd0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_index", bus.index, 0);
    chk("rst_pos_x", bus.pos_x, SX);
    chk("rst_pos_y", bus.pos_y, SY);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_blocked", bus.blocked, 0);
    chk("rst_goal", bus.goal, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    mx = SX;
    my = SY;
  endtask

  // mode 0: plain, 1: stray req pulses, 2: req held through done
  task automatic run_move(input int d, input int mode, input bit pre);
    int tx, ty, nx, ny, lat, de, nd;
    bit blk, gl, oob;
    logic [12:0] idx0;
    ref_move(mx, my, d, tx, ty, nx, ny, blk, gl, oob, lat);
    idx0 = bus.index;
    if (!pre) begin
      bus.req = 1'b1;
      bus.dir = 2'(d);
      @(posedge clk); #1;
      if (mode != 2) bus.req = 1'b0;
    end
    chk("busy_acc", bus.busy, 1);
    de = -1;
    for (int e = 1; e <= 40 && de < 0; e++) begin
      if (mode == 1 && (e == 3 || e == 7)) begin
        bus.req = 1'b1;
        bus.dir = 2'd0;
      end
      @(posedge clk); #1;
      if (mode == 1) begin
        bus.req = 1'b0;
        bus.dir = 2'(d);
      end
      if (!oob && e <= SQ)
        chk($sformatf("index_k%0d", e - 1), bus.index,
            (ty + (e - 1) / S) * 96 + tx + (e - 1) % S);
      if (bus.done) de = e;
    end
    chk("latency", de, lat);
    chk("pos_x", bus.pos_x, nx);
    chk("pos_y", bus.pos_y, ny);
    chk("blocked", bus.blocked, blk);
    chk("goal", bus.goal, gl);
    chk("busy_done", bus.busy, 0);
    if (oob) chk("idx_hold", bus.index, idx0);
    mx = nx;
    my = ny;
    if (mode == 2) begin
      @(posedge clk); #1;
      chk("reaccept", bus.busy, 1);
      chk("done_pulse", bus.done, 0);
      bus.req = 1'b0;
    end else begin
      nd = 0;
      repeat (mode == 1 ? 6 : 1) begin
        @(posedge clk); #1;
        if (bus.done) nd++;
      end
      chk("extra_done", nd, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{3, -1, -1, -1, -1, 5, 4, 0, 0};
    tbl[1] = '{3,  7,  6, -1, -1, 4, 4, 1, 0};
    tbl[2] = '{1, -1, -1,  4,  7, 4, 5, 0, 1};
    tbl[3] = '{0,  5,  3, -1, -1, 4, 4, 1, 0};
    tbl[4] = '{2,  3,  4,  3,  6, 4, 4, 1, 0};
    tbl[5] = '{2, -1, -1,  3,  6, 3, 4, 0, 1};
    tbl[6] = '{0, -1, -1, -1, -1, 4, 3, 0, 0};
    tbl[7] = '{1, 10, 10, -1, -1, 4, 5, 0, 0};

    bus.req = 1'b0;
    bus.dir = 2'd0;
    reset = 1'b1;
    clear_rom();
    #1;

    foreach (tbl[i]) begin
      do_reset();
      clear_rom();
      if (tbl[i].wx >= 0) rom[tbl[i].wy * 96 + tbl[i].wx] = WALL;
      if (tbl[i].gx >= 0) rom[tbl[i].gy * 96 + tbl[i].gx] = GOAL;
      run_move(tbl[i].dir, 0, 0);
      chk($sformatf("tbl%0d_x", i), bus.pos_x, tbl[i].ex);
      chk($sformatf("tbl%0d_y", i), bus.pos_y, tbl[i].ey);
      chk($sformatf("tbl%0d_blk", i), bus.blocked, tbl[i].eb);
      chk($sformatf("tbl%0d_goal", i), bus.goal, tbl[i].eg);
    end

    // goal flag clears on the next open move
    do_reset();
    clear_rom();
    rom[7 * 96 + 4] = GOAL;
    run_move(1, 0, 0);
    chk("goal_set", bus.goal, 1);
    run_move(0, 0, 0);
    chk("goal_clear", bus.goal, 0);
    chk("goal_back_y", bus.pos_y, 4);

    // edges of the screen
    do_reset();
    clear_rom();
    repeat (4) run_move(2, 0, 0);
    chk("left_edge_x", bus.pos_x, 0);
    run_move(2, 0, 0);
    chk("left_oob_blk", bus.blocked, 1);
    chk("left_oob_x", bus.pos_x, 0);
    repeat (93) run_move(3, 0, 0);
    chk("right_edge_x", bus.pos_x, 93);
    run_move(3, 0, 0);
    chk("right_oob_blk", bus.blocked, 1);
    repeat (4) run_move(0, 0, 0);
    chk("top_edge_y", bus.pos_y, 0);
    run_move(0, 0, 0);
    chk("top_oob_blk", bus.blocked, 1);

    // stray req while busy, then req held across done
    do_reset();
    clear_rom();
    run_move(3, 1, 0);
    chk("stray_x", bus.pos_x, 5);
    chk("stray_y", bus.pos_y, 4);
    run_move(3, 2, 0);
    run_move(3, 0, 1);
    chk("held_x", bus.pos_x, 7);

    // reset lands mid-scan
    do_reset();
    clear_rom();
    rom[6 * 96 + 7] = WALL;
    run_move(3, 0, 0);
    chk("pre_rst_blk", bus.blocked, 1);
    rom[6 * 96 + 7] = 16'h0000;
    bus.req = 1'b1;
    bus.dir = 2'd1;
    @(posedge clk); #1;
    bus.req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_index", bus.index, 0);
    chk("mid_pos_x", bus.pos_x, SX);
    chk("mid_pos_y", bus.pos_y, SY);
    chk("mid_busy", bus.busy, 0);
    chk("mid_done", bus.done, 0);
    chk("mid_blocked", bus.blocked, 0);
    chk("mid_goal", bus.goal, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    mx = SX;
    my = SY;
    run_move(1, 0, 0);
    chk("post_rst_y", bus.pos_y, 5);

    // random maze, random walk
    foreach (rom[i]) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) rom[i] = WALL;
      else if (r < 6) rom[i] = GOAL;
      else rom[i] = 16'($urandom) & 16'h7FE0;
    end
    do_reset();
    for (int n = 0; n < 60; n++)
      run_move(int'($urandom_range(0, 3)), 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
